// File: rtl/pulse_level_gen.sv
// pulse_level_gen: turns single-cycle event ticks into level pulses with a
// programmable high width and a minimum low gap between pulses. Ticks that
// arrive while a pulse is in progress are queued in a saturating counter and
// replayed later as separate pulses, back to back where possible.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   tick       one-cycle pulse request, sampled every rising edge
//   high_len   pulse high time in cycles (0 behaves as 1)
//   low_len    minimum low gap after a pulse in cycles (0 behaves as 1)
//   ovf_clr    clears the sticky overflow flag
//   lvl        generated level, high only in the HIGH state
//   busy       a pulse or its trailing gap is in progress
//   done_tick  high during the last HIGH cycle of each pulse
//   pend       number of queued pulses not yet started
//   ovf        sticky flag: a tick was dropped because the queue was full
module pulse_level_gen #(
  parameter int unsigned CW = 8,
  parameter int unsigned PW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic [CW-1:0] high_len,
  input  logic [CW-1:0] low_len,
  input  logic          ovf_clr,
  output logic          lvl,
  output logic          busy,
  output logic          done_tick,
  output logic [PW-1:0] pend,
  output logic          ovf
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHigh = 2'd1,
    StGap  = 2'd2
  } state_e;

  localparam logic [CW-1:0] CntOne  = CW'(1);
  localparam logic [PW-1:0] PendOne = PW'(1);
  localparam logic [PW-1:0] MaxPend = '1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // The high length lives only in cnt, which is loaded on entry to HIGH.
  // The low length must survive the whole HIGH phase, so it is latched.
  logic [CW-1:0] len_l_q, len_l_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          ovf_q, ovf_d;

  logic [CW-1:0] eff_h;
  logic [CW-1:0] eff_l;
  logic          work;
  logic          start;
  logic          last_high;
  logic          drop;

  assign eff_h = (high_len == '0) ? CntOne : high_len;
  assign eff_l = (low_len == '0) ? CntOne : low_len;
  assign work  = tick | (pend_q != '0);

  // Next state and duration counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_l_d   = len_l_q;
    start     = 1'b0;
    last_high = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (work) begin
          start = 1'b1;
        end
      end
      StHigh: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntOne;
        end else begin
          last_high = 1'b1;
          state_d   = StGap;
          cnt_d     = len_l_q - CntOne;
        end
      end
      StGap: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntOne;
        end else if (work) begin
          start = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Entry into HIGH from IDLE or directly from the end of a gap.
    if (start) begin
      state_d = StHigh;
      cnt_d   = eff_h - CntOne;
      len_l_d = eff_l;
    end
  end

  // Pending queue and sticky overflow.
  always_comb begin
    pend_d = pend_q;
    drop   = 1'b0;

    if (start) begin
      // With an empty queue the start consumes the incoming tick directly;
      // with a tick and a non-empty queue one leaves and one joins.
      if ((pend_q != '0) && !tick) begin
        pend_d = pend_q - PendOne;
      end
    end else if (tick) begin
      if (pend_q != MaxPend) begin
        pend_d = pend_q + PendOne;
      end else begin
        drop = 1'b1;
      end
    end

    // A drop wins over a simultaneous clear.
    ovf_d = drop | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_l_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_l_q <= len_l_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs decode the registered state, so reset clears them immediately.
  assign lvl       = (state_q == StHigh);
  assign busy      = (state_q != StIdle);
  assign done_tick = last_high;
  assign pend      = pend_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pulse_level_gen.sv
module tb_pulse_level_gen;

  localparam int CW   = 8;
  localparam int PW   = 4;
  localparam int MAXP = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic [CW-1:0] high_len;
  logic [CW-1:0] low_len;
  logic          ovf_clr;
  logic          lvl;
  logic          busy;
  logic          done_tick;
  logic [PW-1:0] pend;
  logic          ovf;

  always #5 clk = ~clk;

  pulse_level_gen #(
    .CW(CW),
    .PW(PW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .high_len (high_len),
    .low_len  (low_len),
    .ovf_clr  (ovf_clr),
    .lvl      (lvl),
    .busy     (busy),
    .done_tick(done_tick),
    .pend     (pend),
    .ovf      (ovf)
  );

  typedef struct {
    logic lvl;
    logic busy;
    logic done;
    int   pend;
    logic ovf;
  } exp_t;

  exp_t  sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    done_cnt = 0;
  string cur = "none";

  // Reference model: phase + remaining cycles in phase (including current).
  int   m_state;  // 0 idle, 1 high, 2 gap
  int   m_rem;
  int   m_lat_l;
  int   m_pend;
  logic m_ovf;

  task automatic model_reset();
    m_state = 0;
    m_rem   = 0;
    m_lat_l = 1;
    m_pend  = 0;
    m_ovf   = 1'b0;
    sb.delete();
  endtask

  // Predict the outputs after the next edge, push them, advance one edge,
  // then pop and compare against the DUT.
  task automatic step();
    exp_t e;
    int   eh, el;
    bit   tk, work, start, drop;
    tk    = (tick === 1'b1);
    eh    = (high_len == 0) ? 1 : int'(high_len);
    el    = (low_len == 0) ? 1 : int'(low_len);
    work  = tk || (m_pend != 0);
    start = 0;
    drop  = 0;
    case (m_state)
      0: if (work) start = 1;
      1: begin
        if (m_rem > 1) m_rem--;
        else begin
          m_state = 2;
          m_rem   = m_lat_l;
        end
      end
      default: begin
        if (m_rem > 1) m_rem--;
        else if (work) start = 1;
        else m_state = 0;
      end
    endcase
    if (start) begin
      m_state = 1;
      m_rem   = eh;
      m_lat_l = el;
      if (m_pend != 0 && !tk) m_pend--;
    end else if (tk) begin
      if (m_pend < MAXP) m_pend++;
      else drop = 1;
    end
    m_ovf  = drop || (m_ovf && !(ovf_clr === 1'b1));
    e.lvl  = (m_state == 1);
    e.busy = (m_state != 0);
    e.done = (m_state == 1) && (m_rem == 1);
    e.pend = m_pend;
    e.ovf  = m_ovf;
    sb.push_back(e);

    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (done_tick === 1'b1) done_cnt++;
    n_tests++;
    if (lvl !== e.lvl) begin
      n_fail++;
      $display("FAIL %s lvl: got %b want %b at %0t", cur, lvl, e.lvl, $time);
    end
    n_tests++;
    if (busy !== e.busy) begin
      n_fail++;
      $display("FAIL %s busy: got %b want %b at %0t", cur, busy, e.busy, $time);
    end
    n_tests++;
    if (done_tick !== e.done) begin
      n_fail++;
      $display("FAIL %s done_tick: got %b want %b at %0t", cur, done_tick, e.done, $time);
    end
    n_tests++;
    if (pend !== PW'(e.pend)) begin
      n_fail++;
      $display("FAIL %s pend: got %0d want %0d at %0t", cur, pend, e.pend, $time);
    end
    n_tests++;
    if (ovf !== e.ovf) begin
      n_fail++;
      $display("FAIL %s ovf: got %b want %b at %0t", cur, ovf, e.ovf, $time);
    end
  endtask

  // Short reset pulse placed between clock edges.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    cur      = "reset";
    rst      = 1'b1;
    tick     = 1'b0;
    ovf_clr  = 1'b0;
    high_len = 8'd1;
    low_len  = 8'd1;
    model_reset();
    #12;
    n_tests++;
    if ({lvl, busy, done_tick, pend, ovf} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset outputs: got %b want 00000000", {lvl, busy, done_tick, pend, ovf});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [5:0] obs_lvl, obs_done, obs_busy;
    cur      = "single";
    high_len = 8'd3;
    low_len  = 8'd2;
    for (int c = 0; c < 6; c++) begin
      tick = (c == 0);
      step();
      obs_lvl[c]  = lvl;
      obs_done[c] = done_tick;
      obs_busy[c] = busy;
    end
    tick = 1'b0;
    // bit index = cycle - 1
    n_tests++;
    if (obs_lvl !== 6'b000111) begin
      n_fail++;
      $display("FAIL single lvl pattern: got %b want 000111", obs_lvl);
    end
    n_tests++;
    if (obs_done !== 6'b000100) begin
      n_fail++;
      $display("FAIL single done pattern: got %b want 000100", obs_done);
    end
    n_tests++;
    if (obs_busy !== 6'b011111) begin
      n_fail++;
      $display("FAIL single busy pattern: got %b want 011111", obs_busy);
    end
  endtask

  task automatic test_queued();
    logic [8:0] obs_lvl;
    logic [3:0] obs_pend2, obs_pend3;
    logic       busy10;
    cur      = "queued";
    high_len = 8'd2;
    low_len  = 8'd1;
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick = (c < 3);
      step();
      if (c < 9) obs_lvl[c] = lvl;
      if (c == 1) obs_pend2 = pend;
      if (c == 2) obs_pend3 = pend;
      if (c == 9) busy10 = busy;
    end
    tick = 1'b0;
    n_tests++;
    if (obs_lvl !== 9'b011011011) begin
      n_fail++;
      $display("FAIL queued lvl pattern: got %b want 011011011", obs_lvl);
    end
    n_tests++;
    if (obs_pend2 !== 4'd1 || obs_pend3 !== 4'd2) begin
      n_fail++;
      $display("FAIL queued pend: got %0d,%0d want 1,2", obs_pend2, obs_pend3);
    end
    n_tests++;
    if (busy10 !== 1'b0) begin
      n_fail++;
      $display("FAIL queued busy at cycle 10: got %b want 0", busy10);
    end
    n_tests++;
    if (done_cnt != 3) begin
      n_fail++;
      $display("FAIL queued done count: got %0d want 3", done_cnt);
    end
  endtask

  task automatic test_zero_len();
    int guard;
    cur      = "zero_len";
    high_len = 8'd0;
    low_len  = 8'd0;
    done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick = 1'b1;
      step();
    end
    tick  = 1'b0;
    guard = 0;
    while (busy !== 1'b0 && guard < 40) begin
      step();
      guard++;
    end
    n_tests++;
    if (guard >= 40) begin
      n_fail++;
      $display("FAIL zero_len drain timeout: busy=%b pend=%0d", busy, pend);
    end
    n_tests++;
    if (done_cnt != 6) begin
      n_fail++;
      $display("FAIL zero_len pulse count: got %0d want 6", done_cnt);
    end
  endtask

  task automatic test_overflow();
    cur      = "overflow";
    high_len = 8'd255;
    low_len  = 8'd1;
    for (int c = 0; c < 21; c++) begin
      tick = 1'b1;
      step();
    end
    n_tests++;
    if (pend !== 4'd15 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow saturate: got pend=%0d ovf=%b want 15,1", pend, ovf);
    end
    tick    = 1'b0;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    n_tests++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow clear: got %b want 0", ovf);
    end
    tick    = 1'b1;
    ovf_clr = 1'b1;
    step();
    tick    = 1'b0;
    ovf_clr = 1'b0;
    n_tests++;
    if (ovf !== 1'b1 || pend !== 4'd15) begin
      n_fail++;
      $display("FAIL overflow set+clear: got ovf=%b pend=%0d want 1,15", ovf, pend);
    end
    pulse_reset();
  endtask

  task automatic test_len_change();
    logic [9:0] obs_lvl;
    cur      = "len_change";
    high_len = 8'd5;
    low_len  = 8'd1;
    for (int c = 0; c < 10; c++) begin
      tick = (c < 2);
      step();
      obs_lvl[c] = lvl;
      if (c == 1) high_len = 8'd1;
    end
    tick = 1'b0;
    n_tests++;
    if (obs_lvl !== 10'b0001011111) begin
      n_fail++;
      $display("FAIL len_change lvl pattern: got %b want 0001011111", obs_lvl);
    end
  endtask

  task automatic test_async_reset();
    cur      = "async_reset";
    high_len = 8'd20;
    low_len  = 8'd1;
    for (int c = 0; c < 4; c++) begin
      tick = 1'b1;
      step();
    end
    tick = 1'b0;
    n_tests++;
    if (lvl !== 1'b1 || pend !== 4'd3) begin
      n_fail++;
      $display("FAIL async_reset setup: got lvl=%b pend=%0d want 1,3", lvl, pend);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (lvl !== 1'b0 || busy !== 1'b0 || pend !== 4'd0 || done_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset immediate: got lvl=%b busy=%b pend=%0d done=%b want 0,0,0,0",
               lvl, busy, pend, done_tick);
    end
    #1 rst = 1'b0;
    model_reset();
    for (int c = 0; c < 5; c++) step();
    n_tests++;
    if (lvl !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset after release: got lvl=%b busy=%b want 0,0", lvl, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_queued();
    test_zero_len();
    test_overflow();
    test_len_change();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
